fetch_pc_sequencer: RTL

- Owns the fetch-stage PC register and sequences instruction-memory requests.
- Arbitrates next-PC sources by priority: execute redirect (jump/mispredict), then BTB predicted-taken, then sequential PC+4.
- Keeps the imem request stable while it waits for a grant, and latches redirects that arrive during that wait.
- Sits between the BTB, the execute-stage redirect and the IF/ID register.

---
 rtl/fetch_pc_sequencer.sv | 126 ++++++++++++
 1 files changed

// File: rtl/fetch_pc_sequencer.sv
// Fetch-stage PC register and imem request sequencer: redirect > BTB taken > PC+4.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_i,
  input  logic             jump_en,
  input  logic [31:0]      pc_jump_addr,
  input  logic             btb_pc_valid,
  input  logic             btb_pc_predictTaken,
  input  logic [31:0]      btb_target_pc,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_gnt,
  output logic [31:0]      pc_o,
  output logic             flush_o,
  output logic             discard_o,
  output logic [CNT_W-1:0] perf_redirect_cnt,
  output logic [CNT_W-1:0] perf_stall_cnt
);

  localparam logic [1:0] ST_BOOT       = 2'd0;
  localparam logic [1:0] ST_RUN        = 2'd1;
  localparam logic [1:0] ST_HOLD_REDIR = 2'd2;
  localparam logic [31:0] ALIGN_MASK   = 32'hFFFF_FFFC;

  // Handshake: a request is taken only in a cycle where imem_req && imem_gnt.
  // Once raised, imem_req and imem_addr stay stable until that cycle.
  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] redir_q, redir_d;
  logic        lock_q, lock_d;
  logic        accepted;
  logic        btb_taken;

  assign imem_req  = (state_q != ST_BOOT) && (!stall_i || lock_q);
  assign imem_addr = pc_q;
  assign pc_o      = pc_q;
  assign accepted  = imem_req && imem_gnt;
  assign btb_taken = btb_pc_valid && btb_pc_predictTaken;
  assign flush_o   = jump_en && (state_q != ST_BOOT);
  assign discard_o = (state_q == ST_HOLD_REDIR) && accepted;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    redir_d = redir_q;
    lock_d  = lock_q;
    if (imem_req) begin
      lock_d = !imem_gnt;
    end
    case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (accepted) begin
          if (jump_en)        pc_d = pc_jump_addr & ALIGN_MASK;
          else if (btb_taken) pc_d = btb_target_pc & ALIGN_MASK;
          else                pc_d = pc_q + 32'd4;
        end else if (jump_en) begin
          // An outstanding request keeps its address; park the target.
          if (imem_req) begin
            redir_d = pc_jump_addr & ALIGN_MASK;
            state_d = ST_HOLD_REDIR;
          end else begin
            pc_d = pc_jump_addr & ALIGN_MASK;
          end
        end
      end
      ST_HOLD_REDIR: begin
        if (accepted) begin
          pc_d    = jump_en ? (pc_jump_addr & ALIGN_MASK) : redir_q;
          state_d = ST_RUN;
        end else if (jump_en) begin
          redir_d = pc_jump_addr & ALIGN_MASK;
        end
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
      redir_q <= 32'h0;
      lock_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      redir_q <= redir_d;
      lock_q  <= lock_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  logic [CNT_W-1:0] redir_cnt_q, stall_cnt_q;
  logic             stall_cycle;

  assign stall_cycle = ((state_q != ST_BOOT) && !imem_req) || (imem_req && !imem_gnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redir_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (flush_o)     redir_cnt_q <= redir_cnt_q + CNT_ONE;
      if (stall_cycle) stall_cnt_q <= stall_cnt_q + CNT_ONE;
    end
  end

  assign perf_redirect_cnt = redir_cnt_q;
  assign perf_stall_cnt    = stall_cnt_q;
`else
  assign perf_redirect_cnt = '0;
  assign perf_stall_cnt    = '0;
`endif

endmodule
